// File: rtl/neuron_pkg.sv
// Shared types, default widths and the activation transfer function for the
// parametrised MAC neuron.
package neuron_pkg;

    localparam int N_INPUTS_DEF   = 15;
    localparam int DW_DEF         = 9;
    localparam int OUT_W_DEF      = 8;
    localparam int BIAS_SHIFT_DEF = 2;
    localparam int ACC_W_DEF      = 32;

    // Widest accumulator/activation the transfer function can handle.
    localparam int SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACC,
        DONE
    } state_t;

    // The sum arrives sign-extended to SAT_MAX_W. This makes |most-negative|
    // land on bit acc_w-1, which lies outside the saturation window, exactly
    // as in a native acc_w-bit negate.
    function automatic logic [SAT_MAX_W-1:0] sat_act(
        input logic signed [SAT_MAX_W-1:0] sum,
        input logic                        mode,
        input int                          acc_w,
        input int                          out_w,
        input int                          shift
    );
        logic [SAT_MAX_W-1:0] mag;
        logic [SAT_MAX_W-1:0] shifted;
        logic [SAT_MAX_W-1:0] res;
        logic                 sat;
        if (sum[SAT_MAX_W-1]) begin
            mag = mode ? '0 : -sum;
        end else begin
            mag = sum;
        end
        sat = 1'b0;
        for (int b = 0; b < SAT_MAX_W; b++) begin
            if (b >= out_w + shift && b <= acc_w - 2 && mag[b]) begin
                sat = 1'b1;
            end
        end
        shifted = mag >> shift;
        res     = '0;
        for (int b = 0; b < SAT_MAX_W; b++) begin
            if (b < out_w) begin
                res[b] = sat | shifted[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/p_neuron_if.sv
// Config, sample and result handshakes of the neuron plus its side-band
// control and status lines.
interface p_neuron_if #(
    parameter int DW    = 9,
    parameter int OUT_W = 8
);
    logic                    flush;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic signed [DW-1:0]    cfg_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_data;
    logic                    act_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_act;
    logic                    out_fire;
    logic                    loaded;

    modport master (
        output flush, cfg_valid, cfg_data, in_valid, in_data, act_mode, out_ready,
        input  cfg_ready, in_ready, out_valid, out_act, out_fire, loaded
    );

    modport slave (
        input  flush, cfg_valid, cfg_data, in_valid, in_data, act_mode, out_ready,
        output cfg_ready, in_ready, out_valid, out_act, out_fire, loaded
    );
endinterface

// File: rtl/neuron_mac.sv
// Registered multiply-add: acc <= (load ? init : acc) + a*b, sign-extended.
// sum_nxt exposes the value the accumulator takes on this edge.
module neuron_mac #(
    parameter int DW    = 9,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    acc_en,
    input  logic                    clr,
    input  logic signed [DW-1:0]    a,
    input  logic signed [DW-1:0]    b,
    input  logic signed [ACC_W-1:0] init,
    output logic signed [ACC_W-1:0] sum_nxt
);
    logic signed [ACC_W-1:0] acc;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;

    always_comb begin
        prod     = a * b;
        prod_ext = ACC_W'(prod);
        sum_nxt  = (load ? init : acc) + prod_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load || acc_en) begin
            acc <= sum_nxt;
        end
    end
endmodule

// File: rtl/p_neuron.sv
// Serial MAC neuron: streamed bias/weight load, one sample per cycle, and a
// saturated abs/ReLU activation returned over a valid/ready result port.
//
// state | meaning
// IDLE  | weights ready (if loaded); accepts a config word or x[0]
// LOAD  | writing w[idx] from the config stream
// ACC   | accumulating x[idx]*w[idx]
// DONE  | result presented, waiting for out_ready
module p_neuron
    import neuron_pkg::*;
#(
    parameter int N_INPUTS   = N_INPUTS_DEF,
    parameter int DW         = DW_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int BIAS_SHIFT = BIAS_SHIFT_DEF,
    parameter int ACC_W      = ACC_W_DEF
) (
    input logic       clk,
    input logic       rst,
    p_neuron_if.slave bus
);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic signed [DW-1:0]    w [N_INPUTS];
    logic signed [DW-1:0]    bias;
    logic                    loaded_q;
    logic                    mode_q;
    logic [OUT_W-1:0]        act_q;
    logic                    fire_q;

    logic                    flush_hit;
    logic                    cfg_beat;
    logic                    x_first;
    logic                    x_beat;
    logic                    x_last;
    logic                    mode_eff;
    logic signed [DW-1:0]    w_sel;
    logic signed [ACC_W-1:0] init;
    logic signed [ACC_W-1:0] sum_nxt;
    logic [OUT_W-1:0]        sat_res;

    // A config word in IDLE wins over a sample, even though in_ready is high.
    always_comb begin
        flush_hit = bus.flush && (state == LOAD || state == ACC);
        cfg_beat  = bus.cfg_valid && (state == IDLE || state == LOAD) && !flush_hit;
        x_first   = (state == IDLE) && loaded_q && bus.in_valid && !bus.cfg_valid;
        x_beat    = (state == ACC) && bus.in_valid && !flush_hit;
        x_last    = (x_first && N_INPUTS == 1) || (x_beat && idx == LAST_IDX);
        mode_eff  = (state == ACC) ? mode_q : bus.act_mode;
        w_sel     = (state == ACC) ? w[idx] : w[0];
        init      = ACC_W'(bias) <<< BIAS_SHIFT;
        sat_res   = OUT_W'(sat_act(SAT_MAX_W'(sum_nxt), mode_eff, ACC_W, OUT_W, BIAS_SHIFT));
    end

    neuron_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .load    (x_first),
        .acc_en  (x_beat),
        .clr     (flush_hit && state == ACC),
        .a       (bus.in_data),
        .b       (w_sel),
        .init    (init),
        .sum_nxt (sum_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.cfg_valid) begin
                    state_nxt = LOAD;
                end else if (x_first) begin
                    state_nxt = (N_INPUTS == 1) ? DONE : ACC;
                end
            end
            LOAD: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (bus.cfg_valid && idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            ACC: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (x_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cfg_ready = (state == IDLE) || (state == LOAD);
        bus.in_ready  = ((state == IDLE) && loaded_q) || (state == ACC);
        bus.out_valid = (state == DONE);
        bus.out_act   = act_q;
        bus.out_fire  = fire_q;
        bus.loaded    = loaded_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            bias     <= '0;
            loaded_q <= 1'b0;
            mode_q   <= 1'b0;
            act_q    <= '0;
            fire_q   <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                w[i] <= '0;
            end
        end else begin
            if (cfg_beat) begin
                if (state == IDLE) begin
                    bias     <= bus.cfg_data;
                    loaded_q <= 1'b0;
                    idx      <= '0;
                end else begin
                    w[idx] <= bus.cfg_data;
                    if (idx == LAST_IDX) begin
                        loaded_q <= 1'b1;
                        idx      <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            end
            if (flush_hit) begin
                idx <= '0;
            end
            if (x_first) begin
                mode_q <= bus.act_mode;
                idx    <= (N_INPUTS > 1) ? IDX_W'(1) : '0;
            end
            if (x_beat) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            // The result is captured on the edge that accepts the final sample.
            if (x_last) begin
                act_q  <= sat_res;
                fire_q <= sat_res[OUT_W-1];
            end
        end
    end
endmodule

// File: tb/tb_p_neuron.sv
// Bench for p_neuron with three inputs: directed cases plus random weights and
// samples scored against an integer-arithmetic model of the activation.
module tb_p_neuron;
    localparam int N     = 3;
    localparam int DW    = 9;
    localparam int OUT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    p_neuron_if #(.DW(DW), .OUT_W(OUT_W)) bus ();

    p_neuron #(
        .N_INPUTS   (N),
        .DW         (DW),
        .OUT_W      (OUT_W),
        .BIAS_SHIFT (2),
        .ACC_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cur_b;
    int cur_w [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_act(input int x0, input int x1, input int x2, input bit m);
        longint s;
        longint mag;
        s   = longint'(cur_b) * 4 + longint'(x0) * cur_w[0]
            + longint'(x1) * cur_w[1] + longint'(x2) * cur_w[2];
        mag = (s < 0) ? (m ? 0 : -s) : s;
        return (mag >= 1024) ? 255 : int'(mag / 4);
    endfunction

    task automatic send_cfg(input int v);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = DW'(v);
        for (int k = 0; k < 20 && bus.cfg_ready !== 1'b1; k++) tick();
        check("cfg_ready", bus.cfg_ready, 1);
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic load(input int b, input int w0, input int w1, input int w2);
        send_cfg(b);
        send_cfg(w0);
        send_cfg(w1);
        send_cfg(w2);
        cur_b    = b;
        cur_w[0] = w0;
        cur_w[1] = w1;
        cur_w[2] = w2;
        check("loaded_set", bus.loaded, 1);
    endtask

    task automatic send_x(input int v, input bit m);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(v);
        bus.act_mode = m;
        for (int k = 0; k < 20 && bus.in_ready !== 1'b1; k++) tick();
        check("in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic eval(input int x0, input int x1, input int x2, input bit m, input int exp);
        send_x(x0, m);
        send_x(x1, ~m);
        check("valid_early", bus.out_valid, 0);
        send_x(x2, ~m);
        check("out_valid", bus.out_valid, 1);
        check("out_act", 32'(bus.out_act), exp[31:0]);
        check("out_fire", bus.out_fire, exp[7]);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("valid_drop", bus.out_valid, 0);
        check("idle_ready", bus.in_ready, 1);
    endtask

    initial begin
        int x0, x1, x2;
        bit m;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.act_mode  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_loaded", bus.loaded, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_act", 32'(bus.out_act), 0);
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_in_ready", bus.in_ready, 0);

        load(1, 2, 3, 4);
        eval(5, 6, 7, 1'b0, 15);
        eval(-5, -6, -7, 1'b0, 13);
        eval(-5, -6, -7, 1'b1, 0);

        load(0, 16, 0, 0);
        eval(32, 0, 0, 1'b0, 128);
        load(1, 16, 0, 0);
        eval(31, 0, 0, 1'b1, 125);

        load(0, 255, 255, 255);
        eval(255, 255, 255, 1'b1, 255);
        eval(-255, -255, -255, 1'b0, 255);
        eval(-255, -255, -255, 1'b1, 0);

        // Result held under backpressure
        load(1, 2, 3, 4);
        send_x(5, 1'b0);
        send_x(6, 1'b0);
        send_x(7, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_act", 32'(bus.out_act), 15);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_cfg_ready", bus.cfg_ready, 0);
            check("bp_valid", bus.out_valid, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release", bus.out_valid, 0);

        // Flush mid-accumulation keeps weights, discards the partial sum
        send_x(9, 1'b0);
        send_x(9, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_loaded", bus.loaded, 1);
        check("flush_idle", bus.in_ready, 1);
        check("flush_valid", bus.out_valid, 0);
        eval(5, 6, 7, 1'b0, 15);

        // Flush mid-load leaves the set unloaded
        send_cfg(7);
        send_cfg(1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("lflush_loaded", bus.loaded, 0);
        check("lflush_in_ready", bus.in_ready, 0);

        // Reset in the middle of an evaluation
        load(1, 2, 3, 4);
        send_x(5, 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        check("mrst_loaded", bus.loaded, 0);
        check("mrst_in_ready", bus.in_ready, 0);
        tick();
        check("mrst_in_ready2", bus.in_ready, 0);

        // Config beat beats a simultaneous sample in IDLE
        load(1, 2, 3, 4);
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = DW'(0);
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(99);
        tick();
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        check("prio_loaded", bus.loaded, 0);
        check("prio_in_ready", bus.in_ready, 0);
        check("prio_valid", bus.out_valid, 0);
        send_cfg(1);
        send_cfg(1);
        send_cfg(1);
        cur_b = 0;
        cur_w = '{1, 1, 1};
        check("prio_reloaded", bus.loaded, 1);
        eval(4, 4, 4, 1'b0, 3);

        // Random weights and samples
        for (int it = 0; it < 24; it++) begin
            if (it % 6 == 0) begin
                load(int'($urandom_range(0, 510)) - 255,
                     int'($urandom_range(0, 510)) - 255,
                     int'($urandom_range(0, 510)) - 255,
                     int'($urandom_range(0, 510)) - 255);
            end
            x0 = int'($urandom_range(0, 510)) - 255;
            x1 = int'($urandom_range(0, 510)) - 255;
            x2 = (it % 3 == 0) ? int'($urandom_range(0, 8)) - 4 : int'($urandom_range(0, 510)) - 255;
            if (it % 4 == 1) begin
                x0 = int'($urandom_range(0, 6)) - 3;
                x1 = int'($urandom_range(0, 6)) - 3;
            end
            m = 1'($urandom_range(0, 1));
            eval(x0, x1, x2, m, ref_act(x0, x1, x2, m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
